// File: rtl/nvio_memq.sv
// Memory request queue and 128-bit bus sequencer for the load/store path.
// In: req_* (ma/dat/sz/we/tag), ack_i/err_i/dat_i. Out: req_ready_o, bus cyc/stb/we/sel/adr/dat, rsp_*.
module nvio_memq #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int TAGW  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [2:0]      req_sz_i,
    input  logic [79:0]     req_ma_i,
    input  logic [79:0]     req_dat_i,
    input  logic [TAGW-1:0] req_tag_i,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [15:0]     sel_o,
    output logic [AW-1:0]   adr_o,
    output logic [127:0]    dat_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic [127:0]    dat_i,
    output logic            rsp_valid_o,
    output logic [TAGW-1:0] rsp_tag_o,
    output logic [79:0]     rsp_dat_o,
    output logic            rsp_err_o
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

    typedef struct packed {
        logic            we;
        logic [2:0]      sz;
        logic [AW-1:0]   ma;
        logic [79:0]     dat;
        logic [TAGW-1:0] tag;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic [PW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            full, empty, push, pop;

    state_t          state_q, state_d;
    logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [15:0]     sel_q, sel_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [127:0]    dat_q, dat_d;
    logic [255:0]    buf_q, buf_d;
    logic            err_q, err_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
    logic [79:0]     rsp_dat_q, rsp_dat_d;
    logic            rsp_err_q, rsp_err_d;

    logic [3:0]      off, n;
    logic            split;
    logic [31:0]     m;
    logic [255:0]    s;
    logic [79:0]     ld_dat;
    logic            unused_ma;

    // Address bits above the bus width never reach the queue.
    assign unused_ma = ^req_ma_i[79:AW];

    // Extra pointer bit distinguishes full from empty.
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                         (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign req_ready_o = !full;
    assign push        = req_valid_i && !full;
    assign head        = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= '{we: req_we_i, sz: req_sz_i,
                                         ma: req_ma_i[AW-1:0],
                                         dat: req_dat_i, tag: req_tag_i};
        end
    end

    always_comb begin
        case (head.sz)
            3'd0:    n = 4'd1;
            3'd1:    n = 4'd2;
            3'd2:    n = 4'd4;
            3'd3:    n = 4'd5;
            3'd4:    n = 4'd8;
            default: n = 4'd10;
        endcase
    end

    assign off    = head.ma[3:0];
    assign split  = ({1'b0, off} + {1'b0, n}) > 5'd16;
    assign m      = ((32'd1 << n) - 32'd1) << off;
    assign s      = {176'b0, head.dat} << {off, 3'b000};
    // Two-beat buffer realigned to the request offset, trimmed to n bytes.
    assign ld_dat = 80'(buf_q >> {off, 3'b000}) &
                    ((80'd1 << {n, 3'b000}) - 80'd1);

    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{PW{1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{PW{1'b0}}, pop};
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        buf_d       = buf_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_tag_d   = '0;
        rsp_dat_d   = '0;
        rsp_err_d   = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = head.we;
                    adr_d   = {head.ma[AW-1:4], 4'h0};
                    sel_d   = m[15:0];
                    dat_d   = s[127:0];
                    err_d   = 1'b0;
                    state_d = BEAT1;
                end
            end
            BEAT1: begin
                if (err_i || (ack_i && !split)) begin
                    err_d   = err_i;
                    if (!err_i) buf_d[127:0] = dat_i;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    adr_d   = '0;
                    dat_d   = '0;
                    state_d = RESP;
                end else if (ack_i) begin
                    buf_d[127:0] = dat_i;
                    adr_d   = adr_q + AW'(16);
                    sel_d   = m[31:16];
                    dat_d   = s[255:128];
                    state_d = BEAT2;
                end
            end
            BEAT2: begin
                if (err_i || ack_i) begin
                    err_d   = err_i;
                    if (!err_i) buf_d[255:128] = dat_i;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    adr_d   = '0;
                    dat_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_tag_d   = head.tag;
                rsp_err_d   = err_q;
                rsp_dat_d   = (head.we || err_q) ? 80'd0 : ld_dat;
                pop         = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            buf_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            buf_q       <= buf_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cyc_o       = cyc_q;
    assign stb_o       = stb_q;
    assign we_o        = we_q;
    assign sel_o       = sel_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_tag_o   = rsp_tag_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
endmodule
